// File: rtl/ps2_pkg.sv
// Shared constants, frame-state encoding and event layout for the PS/2 keyboard path.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int EVT_W = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // One-hot position of an arrow key in the {up, down, left, right} vector.
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] mask;
        case (code)
            SC_UP:    mask = 4'b1000;
            SC_DOWN:  mask = 4'b0100;
            SC_LEFT:  mask = 4'b0010;
            SC_RIGHT: mask = 4'b0001;
            default:  mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead key-event queue; drops new events when full unless a pop frees a slot that cycle.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             in_clk,
    input  logic             in_reset,
    input  logic             wr_en,
    input  logic [EVT_W-1:0] wr_data,
    input  logic             rd_en,
    output logic             not_empty,
    output logic [EVT_W-1:0] rd_data,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [EVT_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             overflow_r;
    logic             full_s;
    logic             empty_s;
    logic             do_pop_s;
    logic             do_push_s;

    assign full_s    = (count_r == (AW+1)'(DEPTH));
    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign do_pop_s  = rd_en & ~empty_s;
    assign do_push_s = wr_en & (~full_s | do_pop_s);

    // Storage, pointers, occupancy and the overflow pulse.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {EVT_W{1'b0}};
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
            overflow_r <= wr_en & full_s & ~do_pop_s;
        end
    end

    // Head entry is presented directly; zeros when nothing is queued.
    always_comb begin
        if (empty_s) begin
            rd_data = {EVT_W{1'b0}};
        end else begin
            rd_data = mem_r[rd_ptr_r];
        end
    end

    assign not_empty = ~empty_s;
    assign overflow  = overflow_r;

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard front end: pin conditioning, 11-bit framing with timeout, prefix decoding,
// event queueing and live arrow-key state.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       in_clk,
    input  logic       in_reset,
    input  logic       in_ps2_clk,
    input  logic       in_ps2_data,
    input  logic       in_rd,
    output logic       out_valid,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic       out_break,
    output logic [3:0] out_dir,
    output logic       out_frame_err,
    output logic       out_overflow
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]    clk_sync_r;
    logic [1:0]    data_sync_r;
    logic          clk_hist_r;
    logic [1:0]    state_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          par_ok_r;
    logic [TW-1:0] to_cnt_r;
    logic          err_r;
    logic          ext_pend_r;
    logic          brk_pend_r;
    logic [3:0]    dir_r;
    logic          fall_s;
    logic          data_s;
    logic          timeout_s;
    logic          frame_done_s;
    logic          frame_good_s;
    logic          push_s;
    ps2_evt_t      push_evt_s;
    ps2_evt_t      head_s;

    // Two-stage synchronizers plus a history stage on the clock; bus idles high.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
            clk_hist_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], in_ps2_clk};
            data_sync_r <= {data_sync_r[0], in_ps2_data};
            clk_hist_r  <= clk_sync_r[1];
        end
    end

    assign fall_s       = clk_hist_r & ~clk_sync_r[1];
    assign data_s       = data_sync_r[1];
    assign timeout_s    = (state_r != ST_IDLE) & ~fall_s & (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));
    assign frame_done_s = fall_s & (state_r == ST_STOP);
    assign frame_good_s = par_ok_r & data_s;

    // Frame state machine, stepped by detected PS/2 falling edges.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            par_ok_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fall_s && !data_s) begin
                        state_r   <= ST_DATA;
                        bit_cnt_r <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (fall_s) begin
                        shift_r   <= {data_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end
                    end else if (timeout_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PARITY: begin
                    if (fall_s) begin
                        par_ok_r <= odd_parity_ok(shift_r, data_s);
                        state_r  <= ST_STOP;
                    end else if (timeout_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STOP: begin
                    if (fall_s || timeout_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Inactivity counter: only runs inside a frame, restarts on every edge.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            to_cnt_r <= {TW{1'b0}};
        end else if (state_r == ST_IDLE || fall_s || timeout_s) begin
            to_cnt_r <= {TW{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end
    end

    assign push_s = frame_done_s & frame_good_s & (shift_r != SC_EXT) & (shift_r != SC_BRK);

    always_comb begin
        push_evt_s.ext  = ext_pend_r;
        push_evt_s.brk  = brk_pend_r;
        push_evt_s.code = shift_r;
    end

    // Prefix flags, arrow-key state and the framing-error pulse.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
            dir_r      <= 4'b0000;
            err_r      <= 1'b0;
        end else begin
            err_r <= (fall_s & (state_r == ST_IDLE) & data_s) | timeout_s |
                     (frame_done_s & ~frame_good_s);
            if (frame_done_s) begin
                if (!frame_good_s) begin
                    ext_pend_r <= 1'b0;
                    brk_pend_r <= 1'b0;
                end else if (shift_r == SC_EXT) begin
                    ext_pend_r <= 1'b1;
                end else if (shift_r == SC_BRK) begin
                    brk_pend_r <= 1'b1;
                end else begin
                    ext_pend_r <= 1'b0;
                    brk_pend_r <= 1'b0;
                    if (ext_pend_r) begin
                        if (brk_pend_r) begin
                            dir_r <= dir_r & ~arrow_mask(shift_r);
                        end else begin
                            dir_r <= dir_r | arrow_mask(shift_r);
                        end
                    end
                end
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .in_clk    (in_clk),
        .in_reset  (in_reset),
        .wr_en     (push_s),
        .wr_data   (push_evt_s),
        .rd_en     (in_rd),
        .not_empty (out_valid),
        .rd_data   (head_s),
        .overflow  (out_overflow)
    );

    assign out_code      = head_s.code;
    assign out_ext       = head_s.ext;
    assign out_break     = head_s.brk;
    assign out_dir       = dir_r;
    assign out_frame_err = err_r;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a queue-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_ps2_key_ctrl;

    localparam int T = 200;
    localparam int D = 4;

    logic       in_clk = 1'b0;
    logic       in_reset = 1'b1;
    logic       in_ps2_clk = 1'b1;
    logic       in_ps2_data = 1'b1;
    logic       in_rd = 1'b0;
    logic       out_valid;
    logic [7:0] out_code;
    logic       out_ext;
    logic       out_break;
    logic [3:0] out_dir;
    logic       out_frame_err;
    logic       out_overflow;

    always #5 in_clk = ~in_clk;

    ps2_key_ctrl #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(D)) dut (
        .in_clk        (in_clk),
        .in_reset      (in_reset),
        .in_ps2_clk    (in_ps2_clk),
        .in_ps2_data   (in_ps2_data),
        .in_rd         (in_rd),
        .out_valid     (out_valid),
        .out_code      (out_code),
        .out_ext       (out_ext),
        .out_break     (out_break),
        .out_dir       (out_dir),
        .out_frame_err (out_frame_err),
        .out_overflow  (out_overflow)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model state
    logic [9:0] mq[$];
    logic [3:0] mdir = 4'b0000;
    bit         mext = 1'b0;
    bit         mbrk = 1'b0;
    int         pe = 0;
    int         err_at = -1;
    int         ovf_at = -1;
    bit         running = 1'b0;
    logic [9:0] hd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(posedge in_clk) pe <= pe + 1;

    always begin
        @(negedge in_clk);
        #1;
        if (running) begin
            chk("valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) hd = mq[0];
            else hd = 10'h000;
            chk("code", out_code, hd[7:0]);
            chk("ext", out_ext, hd[9]);
            chk("break", out_break, hd[8]);
            chk("dir", out_dir, mdir);
            chk("frame_err", out_frame_err, pe == err_at);
            chk("overflow", out_overflow, pe == ovf_at);
        end
    end

    function automatic logic [10:0] mk(input logic [7:0] d, input bit flip);
        return {1'b1, (~^d) ^ flip, d, 1'b0};
    endfunction

    // Applies a completed (or abandoned) frame to the model at the edge where the DUT acts on it.
    task automatic model_frame(input logic [10:0] b, input int n, input bit rd_with);
        logic [7:0] d;
        logic [3:0] m;
        if (n == 1 && b[0]) begin
            err_at = pe + 1;
        end else if (n < 11) begin
            err_at = pe + 1 + T;
        end else begin
            d = b[8:1];
            if (b[0] !== 1'b0 || b[10] !== 1'b1 || (^b[9:1]) !== 1'b1) begin
                err_at = pe + 1;
                mext = 1'b0;
                mbrk = 1'b0;
            end else if (d == 8'hE0) begin
                mext = 1'b1;
            end else if (d == 8'hF0) begin
                mbrk = 1'b1;
            end else begin
                m = (d == 8'h75) ? 4'b1000 : (d == 8'h72) ? 4'b0100 :
                    (d == 8'h6B) ? 4'b0010 : (d == 8'h74) ? 4'b0001 : 4'b0000;
                if (mext) mdir = mbrk ? (mdir & ~m) : (mdir | m);
                if (rd_with && mq.size() > 0) void'(mq.pop_front());
                if (mq.size() >= D) ovf_at = pe + 1;
                else mq.push_back({mext, mbrk, d});
                mext = 1'b0;
                mbrk = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [10:0] b, input int n, input bit rd_with);
        for (int i = 0; i < n; i++) begin
            @(negedge in_clk);
            in_ps2_data = b[i];
            repeat (3) @(negedge in_clk);
            in_ps2_clk = 1'b0;
            if (i == n - 1) begin
                repeat (2) @(posedge in_clk);
                if (rd_with) begin
                    @(negedge in_clk);
                    in_rd = 1'b1;
                end
                @(posedge in_clk);
                model_frame(b, n, rd_with);
                @(negedge in_clk);
                in_rd = 1'b0;
            end
            repeat (3) @(negedge in_clk);
            in_ps2_clk = 1'b1;
            repeat (3) @(negedge in_clk);
        end
        @(negedge in_clk);
        in_ps2_data = 1'b1;
    endtask

    task automatic pop();
        @(negedge in_clk);
        in_rd = 1'b1;
        @(posedge in_clk);
        if (mq.size() > 0) void'(mq.pop_front());
        @(negedge in_clk);
        in_rd = 1'b0;
    endtask

    logic [7:0] ord [4];

    initial begin
        ord[0] = 8'h1D; ord[1] = 8'h24; ord[2] = 8'h2D; ord[3] = 8'h35;
        repeat (3) @(negedge in_clk);
        running = 1'b1;
        #2;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_dir", out_dir, 4'b0000);
        chk("rst_err", out_frame_err, 1'b0);
        @(negedge in_clk);
        in_reset = 1'b0;
        repeat (5) @(negedge in_clk);

        // Plain make
        send(mk(8'h1C, 1'b0), 11, 1'b0);
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_code", out_code, 8'h1C);
        chk("t1_flags", {out_ext, out_break}, 2'b00);
        pop();

        // Extended arrow make then break
        send(mk(8'hE0, 1'b0), 11, 1'b0);
        send(mk(8'h75, 1'b0), 11, 1'b0);
        chk("t2_dir_make", out_dir, 4'b1000);
        chk("t2_evt1", {out_ext, out_break, out_code}, 10'h275);
        pop();
        send(mk(8'hE0, 1'b0), 11, 1'b0);
        send(mk(8'hF0, 1'b0), 11, 1'b0);
        send(mk(8'h75, 1'b0), 11, 1'b0);
        chk("t2_dir_break", out_dir, 4'b0000);
        chk("t2_evt2", {out_ext, out_break, out_code}, 10'h375);
        pop();

        // Keypad arrow (no E0) leaves out_dir alone
        send(mk(8'h72, 1'b0), 11, 1'b0);
        chk("kp_dir", out_dir, 4'b0000);
        pop();

        // Bad parity, then good break sequence
        send(mk(8'h1C, 1'b1), 11, 1'b0);
        chk("t3_noevt", out_valid, 1'b0);
        send(mk(8'hF0, 1'b0), 11, 1'b0);
        send(mk(8'h1C, 1'b0), 11, 1'b0);
        chk("t3_evt", {out_ext, out_break, out_code}, 10'h11C);
        pop();

        // Bad start bit
        send(11'h7FF, 1, 1'b0);
        repeat (3) @(negedge in_clk);

        // Partial frame then timeout
        send(mk(8'h5A, 1'b0), 7, 1'b0);
        repeat (T + 20) @(negedge in_clk);
        chk("t4_noevt", out_valid, 1'b0);
        send(mk(8'h29, 1'b0), 11, 1'b0);
        chk("t4_evt", out_code, 8'h29);
        pop();

        // Overflow, then simultaneous push and pop while full
        send(mk(8'h15, 1'b0), 11, 1'b0);
        send(mk(8'h1D, 1'b0), 11, 1'b0);
        send(mk(8'h24, 1'b0), 11, 1'b0);
        send(mk(8'h2D, 1'b0), 11, 1'b0);
        send(mk(8'h2C, 1'b0), 11, 1'b0);
        chk("t5_head", out_code, 8'h15);
        send(mk(8'h35, 1'b0), 11, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t5_order", out_code, ord[i]);
            pop();
        end
        chk("t5_empty", out_valid, 1'b0);

        // Reset in the middle of a frame
        send(mk(8'hE0, 1'b0), 11, 1'b0);
        send(mk(8'h6B, 1'b0), 11, 1'b0);
        send(mk(8'h1C, 1'b0), 11, 1'b0);
        chk("t6_pre_dir", out_dir, 4'b0010);
        send(mk(8'h1D, 1'b0), 6, 1'b0);
        @(negedge in_clk);
        in_reset = 1'b1;
        mq.delete();
        mdir = 4'b0000;
        mext = 1'b0;
        mbrk = 1'b0;
        err_at = -1;
        ovf_at = -1;
        repeat (4) @(negedge in_clk);
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_dir", out_dir, 4'b0000);
        in_reset = 1'b0;
        repeat (4) @(negedge in_clk);
        send(mk(8'h1D, 1'b0), 11, 1'b0);
        chk("t6_evt", {out_ext, out_break, out_code}, 10'h01D);
        pop();
        repeat (4) @(negedge in_clk);

        running = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Sequencing controller for the PS/2 keyboard path of the game. It oversamples the PS/2 clock/data pins and frames each 11-bit word with start/parity/stop checking and an inactivity timeout. It strips the E0 (extended) and F0 (break) prefixes into flags and queues complete key events in a small FIFO for the game logic. It also keeps a live held/released state of the four arrow keys for Pacman steering.

## Interface
- TIMEOUT_CYCLES, 50000: in_clk cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- FIFO_DEPTH, 4: event queue entries; power of two, at least 2.
- in_clk  input  1  system clock; sole clock of the block.
- in_reset  input  1  asynchronous, active-high reset.
- in_ps2_clk  input  1  raw PS/2 clock pin; asynchronous.
- in_ps2_data  input  1  raw PS/2 data pin; asynchronous.
- in_rd  input  1  pop the head event; ignored when out_valid=0.
- out_valid  output  1  FIFO non-empty; head event is presented.
- out_code  output  8  head event scan code, prefixes removed.
- out_ext  output  1  head event carried the E0 prefix.
- out_break  output  1  head event carried the F0 prefix (key release).
- out_dir  output  4  held arrow keys {up, down, left, right}; 1 = held.
- out_frame_err  output  1  one-cycle pulse on a bad start, parity or stop bit, or on a timeout.
- out_overflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Pin conditioning:
  - Both pins pass through two synchronizer flops.
  - The clock also passes through a third history flop.
  - A falling edge is history=1 with synchronized=0.
  - Data is sampled from its synchronized copy on that same cycle.
- Frame FSM (advances only on detected falling edges, except on timeout):
  - IDLE: data=0 → DATA with bit count=0. Data=1 → stay in IDLE and pulse out_frame_err.
  - DATA: shift the bit in LSB-first. After bit 7 → PARITY.
  - PARITY: record the parity check. The 8 data bits plus the parity bit must have odd ones-count. → STOP.
  - STOP: data must be 1. The byte is good only if parity and stop both pass. → IDLE.
- Timeout:
  - The counter clears on every falling edge and whenever the FSM is in IDLE.
  - In any other state, counter reaching TIMEOUT_CYCLES-1 → IDLE, pulse out_frame_err, discard the partial byte.
- Decoder (acts on each completed frame):
  - Bad frame: clear the ext_pend and brk_pend flags; no push.
  - Good 0xE0: set ext_pend; no push.
  - Good 0xF0: set brk_pend; no push.
  - Any other good byte: push event {ext_pend, brk_pend, byte}, then clear both flags.
  - Arrow codes with ext_pend=1: 0x75 up, 0x72 down, 0x6B left, 0x74 right. The matching out_dir bit is set on make and cleared on break.
  - The out_dir update happens even if the push is dropped.
  - An arrow code without E0 (keypad) does not touch out_dir.
- FIFO:
  - Show-ahead: outputs always reflect the head entry and are 0 when empty.
  - Push when full without a pop: drop the new event and pulse out_overflow.
  - Push and pop in the same cycle while full: both happen; count unchanged; no overflow.
  - in_rd while empty: no effect.
- Reset: FSM → IDLE, counters 0, ext_pend/brk_pend 0, FIFO empty, synchronizer flops 1 (idle-high bus). All outputs 0.

## Timing
- Pin falling edge to detected edge: 3 in_clk cycles.
- Let cycle S be the cycle in which the stop-bit edge is detected. The pushed event appears on out_valid/out_code/out_ext/out_break at S+1, and out_dir updates at S+1.
- out_frame_err for a bad frame pulses at S+1. A bad start bit is reported on the start edge +1. A timeout is reported one cycle after the counter hits its limit.
- Pop: in_rd high at cycle P with out_valid=1 → the next entry (or out_valid=0) is presented at P+1.
- Reset asserted mid-frame aborts the frame immediately. The first frame after release must begin with a fresh start bit.
- Back-to-back frames with no idle gap are accepted; IDLE accepts a start bit on the very next edge.

## Structure
- Package ps2_pkg:
  - Constants: SC_EXT=0xE0, SC_BRK=0xF0, SC_UP=0x75, SC_DOWN=0x72, SC_LEFT=0x6B, SC_RIGHT=0x74.
  - Frame FSM state encoding (IDLE, DATA, PARITY, STOP).
  - Event width 10 with field layout {ext, brk, code[7:0]}.
- One sub-module, ps2_event_fifo: parameterized depth, 10-bit entries, show-ahead, wrap-around pointers with a full/empty count.
- Framing, timeout, decoder and out_dir logic stay in ps2_key_ctrl.

## Test plan
- Make 0x1C with valid parity and stop → one event: out_code=0x1C, ext=0, brk=0; out_valid at S+1; no error pulse.
- Bytes E0, 75 then E0, F0, 75 → out_dir=1000 after the first event and 0000 after the second. Events: {1,0,0x75}, then {1,1,0x75}.
- 0x1C sent with a flipped parity bit → out_frame_err pulse, no event. The following good F0, 1C → single event {0,1,0x1C}.
- 6 data bits, then a gap longer than TIMEOUT_CYCLES → one out_frame_err pulse, FSM in IDLE. The next complete frame 0x29 → event 0x29.
- Five makes with in_rd held 0 → 4 queued, one out_overflow pulse on the fifth. Then pop on the same cycle as a sixth push → no overflow, count stays 4, order preserved.
- Assert in_reset during bit 4 of a frame → all outputs 0, FIFO empty. A clean frame 0x1D after release → event 0x1D.
